keypad_conditioner: RTL

- Upstream front-end for the microwave oven controller.
- Samples the raw 10-bit one-hot keypad (bit n = digit n) and debounces it.
- Rejects multi-key and bouncing patterns; emits exactly one single-cycle BCD digit strobe per physical key press.
- The oven's time-entry logic consumes digit/digit_valid instead of the raw keypad, so holding a key no longer re-enters the digit on every clock.

---
 rtl/oven_pkg.sv | 30 +++
 rtl/onehot_to_bcd.sv | 38 +++
 rtl/keypad_conditioner.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/oven_pkg.sv
// oven_pkg
// Shared definitions for the microwave oven front-end blocks.
//   state_t           : keypad debounce FSM states (2-bit)
//   DEBOUNCE_DEFAULT  : default number of identical samples to accept a change
//   KEYPAD_W          : number of raw keypad lines (one per digit 0..9)
//   bcd_bit_mask()    : one-hot positions whose index has BCD bit b set
package oven_pkg;

    localparam int KEYPAD_W         = 10;
    localparam int DEBOUNCE_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_CANDIDATE    = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    // Bit j of the result is set when digit j has BCD bit b set, so
    // OR-reducing (onehot & mask) yields that BCD bit for a one-hot input.
    function automatic logic [KEYPAD_W-1:0] bcd_bit_mask(input int b);
        logic [KEYPAD_W-1:0] m;
        m = '0;
        for (int j = 0; j < KEYPAD_W; j++) begin
            m[j] = (((j >> b) & 1) == 1);
        end
        return m;
    endfunction

endpackage

// File: rtl/onehot_to_bcd.sv
// onehot_to_bcd
// Combinational classifier for a one-hot digit bus.
// Ports:
//   onehot [KEYPAD_W-1:0] in  : bit n = digit n
//   bcd    [3:0]          out : BCD value of the set bit (meaningful only when single=1)
//   single                out : exactly one bit set
//   multi                 out : two or more bits set
module onehot_to_bcd
    import oven_pkg::*;
(
    input  logic [KEYPAD_W-1:0] onehot,
    output logic [3:0]          bcd,
    output logic                single,
    output logic                multi
);

    logic [3:0] ones_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bcd
            localparam logic [KEYPAD_W-1:0] MASK = bcd_bit_mask(gi);
            assign bcd[gi] = |(onehot & MASK);
        end
    endgenerate

    // Population count, only needed to tell ZERO / SINGLE / MULTI apart.
    always_comb begin
        ones_cnt = 4'd0;
        for (int j = 0; j < KEYPAD_W; j++) begin
            ones_cnt = ones_cnt + {3'd0, onehot[j]};
        end
    end

    assign single = (ones_cnt == 4'd1);
    assign multi  = (ones_cnt > 4'd1);

endmodule

// File: rtl/keypad_conditioner.sv
// keypad_conditioner
// Synchronizes and debounces the raw one-hot oven keypad and emits one
// single-cycle BCD strobe per physical key press.
// Ports:
//   clock        in  : system clock (100 Hz)
//   reset        in  : synchronous, active-high reset
//   keypad [9:0] in  : raw one-hot key lines, asynchronous to clock
//   enable       in  : digit entry allowed; sampled when the strobe would fire
//   digit  [3:0] out : BCD of the last accepted key, held between strobes
//   digit_valid  out : one-cycle strobe, digit valid while high
//   key_held     out : high while a press is accepted and not yet released
//   multi_key    out : registered flag, current sample has >1 key down
module keypad_conditioner
    import oven_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [KEYPAD_W-1:0] keypad,
    input  logic                enable,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                key_held,
    output logic                multi_key
);

    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Two-flop synchronizer. Deliberately not reset: after reset it must keep
    // tracking the pins so a key held across reset is seen as non-zero by
    // WAIT_RELEASE immediately rather than as a brief run of zeros.
    logic [KEYPAD_W-1:0] key_meta_reg;
    logic [KEYPAD_W-1:0] key_s_reg;

    always_ff @(posedge clock) begin
        key_meta_reg <= keypad;
        key_s_reg    <= key_meta_reg;
    end

    logic [3:0] key_bcd;
    logic       key_single;
    logic       key_multi;
    logic       key_zero;

    onehot_to_bcd u_classify (
        .onehot (key_s_reg),
        .bcd    (key_bcd),
        .single (key_single),
        .multi  (key_multi)
    );

    assign key_zero = (key_s_reg == '0);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [KEYPAD_W-1:0] cand_reg, cand_next;
    logic [3:0]          digit_reg, digit_next;
    logic                valid_reg, valid_next;
    logic                multi_reg;
    logic [CNT_W-1:0]    cnt_inc;

    // Saturating increment; the counter must never wrap back below target.
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_WAIT_RELEASE;
            cnt_reg   <= '0;
            cand_reg  <= '0;
            digit_reg <= 4'd0;
            valid_reg <= 1'b0;
            multi_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            digit_reg <= digit_next;
            valid_reg <= valid_next;
            multi_reg <= key_multi;
        end
    end

    // cnt holds the number of matching samples already seen; the sample being
    // evaluated is number cnt_inc, so the transition fires when that reaches
    // the target.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        digit_next = digit_reg;
        valid_next = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (key_single) begin
                    state_next = ST_CANDIDATE;
                    cand_next  = key_s_reg;
                    cnt_next   = CNT_ONE;
                end
            end

            ST_CANDIDATE: begin
                if (key_s_reg == cand_reg) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= CNT_TARGET) begin
                        state_next = ST_PRESSED;
                        // The press is consumed even when entry is disabled.
                        if (enable) begin
                            digit_next = key_bcd;
                            valid_next = 1'b1;
                        end
                    end
                end else begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end

            ST_PRESSED: begin
                // Rollover to a different key is ignored; only a full release
                // re-arms the detector.
                if (key_zero) begin
                    state_next = ST_WAIT_RELEASE;
                    cnt_next   = CNT_ONE;
                end
            end

            ST_WAIT_RELEASE: begin
                if (key_zero) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= CNT_TARGET) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = '0;
                end
            end

            default: begin
                state_next = ST_WAIT_RELEASE;
                cnt_next   = '0;
            end
        endcase
    end

    assign digit       = digit_reg;
    assign digit_valid = valid_reg;
    assign key_held    = (state_reg == ST_PRESSED);
    assign multi_key   = multi_reg;

endmodule
